// File: rtl/pipe_multiplier.sv
// pipe_multiplier: three-stage pipelined WIDTH x WIDTH integer multiplier.
//   Stage 1 (PP)  : AND partial-product array (Baugh-Wooley inversion when signed)
//   Stage 2 (RED) : full-adder carry-save compression down to two rows a, b
//   Stage 3 (ADD) : Sklansky parallel-prefix sum a + b -> out_prod
// A single global advance (!out_valid || out_ready) shifts all stages together.
// Build option: define PIPE_MULT_SIGNED_EN to honour in_signed per operation;
// without it every operation is unsigned and in_signed is ignored.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready depends on out_* only)
//   in_x, in_y            operands (WIDTH bits)
//   in_signed             two's-complement select
//   in_tag                side-band tag returned with the product
//   out_valid/out_ready   result handshake
//   out_prod              2*WIDTH-bit product
//   out_tag               tag of out_prod
module pipe_multiplier #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned LVL = $clog2(PW);

`ifdef PIPE_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic             advance;
  logic             sgn_in;
  logic [WIDTH-1:0] pp_c [WIDTH];

  logic             s1_valid;
  logic             s1_sgn;
  logic [WIDTH-1:0] s1_pp [WIDTH];
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [PW-1:0]    s2_a;
  logic [PW-1:0]    s2_b;
  logic [TAG_W-1:0] s2_tag;

  logic [PW-1:0]    red_a_c;
  logic [PW-1:0]    red_b_c;
  logic [PW-1:0]    sum_c;

  // Whole pipe moves as one; bubbles are kept, never collapsed.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign sgn_in   = in_signed & SIGNED_EN;

  // Partial products: row i is in_y[i] AND in_x. Signed mode inverts every
  // term that involves exactly one operand MSB (Baugh-Wooley).
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      for (int j = 0; j < int'(WIDTH); j++) begin
        pp_c[i][j] = (in_x[j] & in_y[i]) ^
                     (sgn_in & ((i == int'(WIDTH) - 1) != (j == int'(WIDTH) - 1)));
      end
    end
  end

  // Carry-save compression of the shifted rows plus the Baugh-Wooley
  // correction row (+2^WIDTH + 2^(2*WIDTH-1)); carries out of the top bit
  // are dropped since the result is modulo 2^(2*WIDTH).
  always_comb begin
    logic [PW-1:0] row;
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] t;
    s = PW'(s1_pp[0]);
    c = PW'(s1_pp[1]) << 1;
    for (int k = 2; k < int'(WIDTH); k++) begin
      row = PW'(s1_pp[k]) << k;
      t   = s ^ c ^ row;
      c   = ((s & c) | (s & row) | (c & row)) << 1;
      s   = t;
    end
    row            = '0;
    row[WIDTH]     = s1_sgn;
    row[PW-1]      = s1_sgn;
    t              = s ^ c ^ row;
    c              = ((s & c) | (s & row) | (c & row)) << 1;
    s              = t;
    red_a_c        = s;
    red_b_c        = c;
  end

  // Sklansky prefix adder. At level l every bit with index bit l set merges
  // with the top bit of the preceding 2^l block. Cells whose group reaches
  // bit 0 only need the generate term (grey); the propagate is carried along.
  always_comb begin
    logic [PW-1:0] g [LVL+1];
    logic [PW-1:0] p [LVL+1];
    int            j;
    g[0] = s2_a & s2_b;
    p[0] = s2_a ^ s2_b;
    for (int l = 0; l < int'(LVL); l++) begin
      g[l+1] = g[l];
      p[l+1] = p[l];
      for (int i = 0; i < int'(PW); i++) begin
        if (((i >> l) & 1) == 1) begin
          j         = ((i >> l) << l) - 1;
          g[l+1][i] = g[l][i] | (p[l][i] & g[l][j]);
          p[l+1][i] = p[l][i] & p[l][j];
        end
      end
    end
    sum_c[0] = p[0][0];
    for (int i = 1; i < int'(PW); i++) begin
      sum_c[i] = p[0][i] ^ g[LVL][i-1];
    end
  end

  // Stage registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sgn    <= 1'b0;
      s1_pp     <= '{default: '0};
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_a      <= '0;
      s2_b      <= '0;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_sgn    <= sgn_in;
      s1_pp     <= pp_c;
      s1_tag    <= in_tag;
      s2_valid  <= s1_valid;
      s2_a      <= red_a_c;
      s2_b      <= red_b_c;
      s2_tag    <= s1_tag;
      out_valid <= s2_valid;
      out_prod  <= sum_c;
      out_tag   <= s2_tag;
    end
  end

endmodule

// File: tb/tb_pipe_multiplier.sv
module tb_pipe_multiplier;

`ifdef PIPE_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst_n;
  // WIDTH=4, TAG_W=4 instance
  logic       in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [3:0] in_x, in_y, in_tag, out_tag;
  logic [7:0] out_prod;
  // WIDTH=8, TAG_W=2 instance
  logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8;
  logic [7:0]  in_x8, in_y8;
  logic [1:0]  in_tag8, out_tag8;
  logic [15:0] out_prod8;

  pipe_multiplier #(.WIDTH(4), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod), .out_tag(out_tag)
  );

  pipe_multiplier #(.WIDTH(8), .TAG_W(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_x(in_x8), .in_y(in_y8), .in_signed(in_signed8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_prod(out_prod8), .out_tag(out_tag8)
  );

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y,
                                         input logic s);
    logic [15:0] xe;
    logic [15:0] ye;
    if (s && SIGNED_EN) begin
      xe = {{8{x[7]}}, x};
      ye = {{8{y[7]}}, y};
    end else begin
      xe = {8'h00, x};
      ye = {8'h00, y};
    end
    return xe * ye;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_x = 4'd15; in_y = 4'd15; in_tag = 4'd7;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_prod !== 8'h00) begin errors++; $display("FAIL reset_prod got %h exp 00", out_prod); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_tag got %h exp 0", out_tag); end
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_valid8 got %b exp 0", out_valid8); end
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_post_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_unsigned_corners();
    logic [3:0] xs [3] = '{4'd15, 4'd0, 4'd1};
    logic [3:0] ys [3] = '{4'd15, 4'd9, 4'd13};
    logic [7:0] ex [3] = '{8'hE1, 8'h00, 8'h0D};
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_x = xs[k]; in_y = ys[k]; in_signed = 1'b0; in_tag = 4'(9 + k);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL unsigned_in_ready[%0d] got %b exp 1", k, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unsigned_early1[%0d] got %b exp 0", k, out_valid); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unsigned_early2[%0d] got %b exp 0", k, out_valid); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL unsigned_valid[%0d] got %b exp 1", k, out_valid); end
      checks++; if (out_prod !== ex[k]) begin errors++; $display("FAIL unsigned_prod[%0d] got %h exp %h", k, out_prod, ex[k]); end
      checks++; if (out_tag !== 4'(9 + k)) begin errors++; $display("FAIL unsigned_tag[%0d] got %h exp %h", k, out_tag, 4'(9 + k)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_signed_patterns();
    logic [3:0] xs [3] = '{4'd8, 4'd8, 4'd15};
    logic [3:0] ys [3] = '{4'd8, 4'd7, 4'd1};
    logic [7:0] ex_s [3] = '{8'h40, 8'hC8, 8'hFF};
    logic [7:0] ex_u [3] = '{8'h40, 8'h38, 8'h0F};
    logic [7:0] ex [3];
    logic [7:0] mix [3];
    for (int k = 0; k < 3; k++) ex[k] = SIGNED_EN ? ex_s[k] : ex_u[k];
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_x = xs[k]; in_y = ys[k]; in_signed = 1'b1; in_tag = 4'(k + 4);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL signed_valid[%0d] got %b exp 1", k, out_valid); end
      checks++; if (out_prod !== ex[k]) begin errors++; $display("FAIL signed_prod[%0d] got %h exp %h", k, out_prod, ex[k]); end
      checks++; if (out_tag !== 4'(k + 4)) begin errors++; $display("FAIL signed_tag[%0d] got %h exp %h", k, out_tag, 4'(k + 4)); end
      @(posedge clk); #1;
    end
    // mixed signed / unsigned / signed stream of 8 x 7, back to back
    mix[0] = SIGNED_EN ? 8'hC8 : 8'h38;
    mix[1] = 8'h38;
    mix[2] = mix[0];
    for (int e = 0; e < 5; e++) begin
      in_valid = (e < 3); in_x = 4'd8; in_y = 4'd7; in_signed = (e != 1); in_tag = 4'(e);
      @(posedge clk); #1;
      if (e >= 2) begin
        checks++; if (out_valid !== 1'b1 || out_prod !== mix[e-2]) begin
          errors++; $display("FAIL mixed_prod[%0d] got %b/%h exp 1/%h", e - 2, out_valid, out_prod, mix[e-2]);
        end
      end
    end
    in_valid = 1'b0; in_signed = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_p [256];
    logic [3:0] exp_t [256];
    out_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      exp_p[k] = 8'((k >> 4) * (k & 15));
      exp_t[k] = 4'(k % 16);
    end
    for (int e = 0; e < 258; e++) begin
      in_valid = (e < 256); in_x = 4'(e >> 4); in_y = 4'(e & 15); in_tag = 4'(e % 16);
      @(posedge clk); #1;
      if (e >= 2) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", e - 2, out_valid); end
        checks++; if (out_prod !== exp_p[e-2]) begin errors++; $display("FAIL b2b_prod[%0d] got %h exp %h", e - 2, out_prod, exp_p[e-2]); end
        checks++; if (out_tag !== exp_t[e-2]) begin errors++; $display("FAIL b2b_tag[%0d] got %h exp %h", e - 2, out_tag, exp_t[e-2]); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_fill_valid[%0d] got %b exp 0", e, out_valid); end
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [3:0] xs [3] = '{4'd3, 4'd7, 4'd12};
    logic [3:0] ys [3] = '{4'd5, 4'd9, 4'd11};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_x = xs[k]; in_y = ys[k]; in_tag = 4'(k + 1);
      @(posedge clk); #1;
    end
    // pipe full, op 0 on the output; stall with a further op offered
    out_ready = 1'b0; in_valid = 1'b1; in_x = 4'd2; in_y = 4'd2; in_tag = 4'd4;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b exp 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_prod !== 8'h0F || out_tag !== 4'd1) begin
        errors++; $display("FAIL stall_hold[%0d] got %b/%h/%h exp 1/0f/1", c, out_valid, out_prod, out_tag);
      end
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_prod !== 8'h3F || out_tag !== 4'd2) begin
      errors++; $display("FAIL drain1 got %b/%h/%h exp 1/3f/2", out_valid, out_prod, out_tag);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_prod !== 8'h84 || out_tag !== 4'd3) begin
      errors++; $display("FAIL drain2 got %b/%h/%h exp 1/84/3", out_valid, out_prod, out_tag);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_x = 4'(k + 5); in_y = 4'd3; in_tag = 4'(k + 10);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
    checks++; if (out_prod !== 8'h00) begin errors++; $display("FAIL midrst_prod got %h exp 00", out_prod); end
    rst_n = 1'b1; in_valid = 1'b1; in_x = 4'd6; in_y = 4'd7; in_tag = 4'd5;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_flush1 got %b exp 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_flush2 got %b exp 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_prod !== 8'h2A || out_tag !== 4'd5) begin
      errors++; $display("FAIL midrst_result got %b/%h/%h exp 1/2a/5", out_valid, out_prod, out_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width8();
    logic [15:0] qp [$];
    logic [1:0]  qt [$];
    int sent = 0;
    int cyc = 0;
    int n_ops = 400;
    logic [15:0] ep;
    logic [1:0]  et;
    // directed corners
    out_ready8 = 1'b1; in_valid8 = 1'b1; in_x8 = 8'd255; in_y8 = 8'd255; in_signed8 = 1'b0; in_tag8 = 2'd2;
    @(posedge clk); #1;
    in_x8 = 8'd128; in_y8 = 8'd128; in_signed8 = 1'b1; in_tag8 = 2'd1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL w8_early got %b exp 0", out_valid8); end
    @(posedge clk); #1;
    checks++; if (out_valid8 !== 1'b1 || out_prod8 !== 16'hFE01 || out_tag8 !== 2'd2) begin
      errors++; $display("FAIL w8_max got %b/%h/%h exp 1/fe01/2", out_valid8, out_prod8, out_tag8);
    end
    @(posedge clk); #1;
    checks++; if (out_valid8 !== 1'b1 || out_prod8 !== 16'h4000 || out_tag8 !== 2'd1) begin
      errors++; $display("FAIL w8_minneg got %b/%h/%h exp 1/4000/1", out_valid8, out_prod8, out_tag8);
    end
    @(posedge clk); #1;
    // randomized valid/ready with in-order scoreboard
    while ((sent < n_ops || qp.size() > 0) && cyc < 5000) begin
      in_valid8  = (sent < n_ops) && ($urandom_range(0, 3) != 0);
      in_x8      = 8'($urandom);
      in_y8      = 8'($urandom);
      in_signed8 = 1'($urandom_range(0, 1));
      in_tag8    = 2'(sent);
      out_ready8 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid8 && out_ready8) begin
        checks++;
        if (qp.size() == 0) begin
          errors++; $display("FAIL w8_rand_spurious got %h exp none", out_prod8);
        end else begin
          ep = qp.pop_front(); et = qt.pop_front();
          if (out_prod8 !== ep || out_tag8 !== et) begin
            errors++; $display("FAIL w8_rand got %h/%h exp %h/%h", out_prod8, out_tag8, ep, et);
          end
        end
      end
      if (in_valid8 && in_ready8) begin
        qp.push_back(model8(in_x8, in_y8, in_signed8));
        qt.push_back(in_tag8);
        sent++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    checks++; if (sent != n_ops || qp.size() != 0) begin
      errors++; $display("FAIL w8_rand_timeout got sent=%0d pending=%0d exp %0d/0", sent, qp.size(), n_ops);
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_x8 = '0; in_y8 = '0; in_signed8 = 1'b0; in_tag8 = '0; out_ready8 = 1'b1;
    test_reset();
    test_unsigned_corners();
    test_signed_patterns();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
